// File: rtl/product_accumulator.sv
// Purpose : sums a burst of N_TERMS products into a saturating ACC_W-bit accumulator.
// Latency : acc_out/count update 1 cycle after an accepting edge; done pulses the cycle after the Nth transfer.
// Backpr. : in_ready is high only while accumulating; a product transfers on in_valid && in_ready.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begins a burst (only honoured in IDLE)
//   product/in_valid  product term and its valid; in_ready accepts it
//   acc_out, count    running/final sum and number of products accepted
//   busy, done        busy in ACCUM/DONE; done is a one-cycle completion pulse
//   overflow          sticky saturation flag for the current burst
module product_accumulator #(
  parameter int PROD_W  = 4,
  parameter int ACC_W   = 8,
  parameter int N_TERMS = 4,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PROD_W-1:0] product,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t         state;
  state_t         state_nxt;
  logic           xfer;
  logic [ACC_W:0] sum;

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid && in_ready;

  // One extra bit catches the carry out; product is zero-extended.
  assign sum = {1'b0, acc_out} + (ACC_W + 1)'(product);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (xfer && (count == LAST_CNT)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out  <= '0;
      count    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Registered so done is high exactly while the FSM sits in DONE.
      done <= (state_nxt == DONE);
      if ((state == IDLE) && start) begin
        acc_out  <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (xfer) begin
        count <= count + CNT_W'(1);
        // Saturated value plus any product carries out again, so the
        // accumulator stays pinned at max for the rest of the burst.
        if (sum[ACC_W]) begin
          acc_out  <= '1;
          overflow <= 1'b1;
        end else begin
          acc_out <= sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [3:0]    product;

  logic          in_ready_a, busy_a, done_a, ovf_a;
  logic [7:0]    acc_a;
  logic [CW-1:0] count_a;
  logic          in_ready_b, busy_b, done_b, ovf_b;
  logic [4:0]    acc_b;
  logic [CW-1:0] count_b;

  int checks   = 0;
  int failures = 0;

  // Reference: products accepted in the current/last burst, plus burst phase
  // (0 = idle, 1 = collecting, 2 = completion cycle).
  int q[$];
  int phase = 0;

  product_accumulator #(.PROD_W(4), .ACC_W(8), .N_TERMS(N)) dut_a (
    .clk(clk), .rst(rst), .start(start), .product(product), .in_valid(in_valid),
    .in_ready(in_ready_a), .acc_out(acc_a), .count(count_a), .busy(busy_a),
    .done(done_a), .overflow(ovf_a)
  );

  product_accumulator #(.PROD_W(4), .ACC_W(5), .N_TERMS(N)) dut_b (
    .clk(clk), .rst(rst), .start(start), .product(product), .in_valid(in_valid),
    .in_ready(in_ready_b), .acc_out(acc_b), .count(count_b), .busy(busy_b),
    .done(done_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qsum();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  task automatic model_edge();
    if (rst) begin
      phase = 0;
      q.delete();
    end else begin
      case (phase)
        0: if (start) begin q.delete(); phase = 1; end
        1: if (in_valid) begin
             q.push_back(int'(product));
             if (q.size() == N) phase = 2;
           end
        default: phase = 0;
      endcase
    end
  endtask

  task automatic check_all();
    int s;
    s = qsum();
    chk("acc_a",      acc_a,      (s > 255) ? 255 : s);
    chk("ovf_a",      ovf_a,      (s > 255) ? 1 : 0);
    chk("acc_b",      acc_b,      (s > 31) ? 31 : s);
    chk("ovf_b",      ovf_b,      (s > 31) ? 1 : 0);
    chk("count_a",    count_a,    q.size());
    chk("count_b",    count_b,    q.size());
    chk("done_a",     done_a,     (phase == 2) ? 1 : 0);
    chk("done_b",     done_b,     (phase == 2) ? 1 : 0);
    chk("busy_a",     busy_a,     (phase != 0) ? 1 : 0);
    chk("in_ready_a", in_ready_a, (phase == 1) ? 1 : 0);
    chk("in_ready_b", in_ready_b, (phase == 1) ? 1 : 0);
  endtask

  // Inputs change only 1 time unit after a rising edge.
  task automatic drive(input bit s, input bit v, input int p);
    start    = s;
    in_valid = v;
    product  = 4'(p);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; product = '0;
    #2;

    // Reset state
    do_reset();
    chk("rst_acc", acc_a, 0);

    // Basic burst 0,1,4,9
    drive(1, 0, 0);
    drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 4); drive(0, 1, 9);
    chk("t1_sum", acc_a, 14);
    chk("t1_done", done_a, 1);
    drive(0, 0, 0);

    // Bubbles: 4,_,_,9,_,1,1
    drive(1, 0, 0);
    drive(0, 1, 4); drive(0, 0, 7); drive(0, 0, 7); drive(0, 1, 9);
    drive(0, 0, 3); drive(0, 1, 1);
    chk("t2_nodone", done_a, 0);
    drive(0, 1, 1);
    chk("t2_sum", acc_a, 15);
    drive(0, 0, 0);

    // Saturation on the 5-bit instance
    drive(1, 0, 0);
    drive(0, 1, 9); drive(0, 1, 9); drive(0, 1, 9);
    chk("t3_27", acc_b, 27);
    chk("t3_noovf", ovf_b, 0);
    drive(0, 1, 9);
    chk("t3_sat", acc_b, 31);
    chk("t3_ovf", ovf_b, 1);
    drive(0, 0, 0);

    // Ignored inputs: valid in IDLE, start mid-burst
    drive(0, 1, 9); drive(0, 1, 9);
    chk("t4_idle_hold", acc_a, 36);
    drive(1, 0, 0);
    drive(0, 1, 2); drive(1, 1, 2); drive(1, 0, 0); drive(0, 1, 2); drive(0, 1, 2);
    chk("t4_sum", acc_a, 8);
    drive(0, 0, 0);

    // Reset mid-burst, then a fresh burst
    drive(1, 0, 0);
    drive(0, 1, 5); drive(0, 1, 5);
    do_reset();
    chk("t5_rst_acc", acc_a, 0);
    chk("t5_rst_done", done_a, 0);
    drive(1, 0, 0);
    drive(0, 1, 1); drive(0, 1, 1); drive(0, 1, 1); drive(0, 1, 1);
    chk("t5_sum", acc_a, 4);
    drive(0, 0, 0);

    // Back-to-back: start in DONE ignored, start in IDLE clears
    drive(1, 0, 0);
    drive(0, 1, 9); drive(0, 1, 9); drive(0, 1, 9); drive(0, 1, 9);
    drive(1, 0, 0);
    chk("t6_ignored_busy", busy_b, 0);
    chk("t6_hold", acc_b, 31);
    drive(1, 0, 0);
    chk("t6_clear_acc", acc_b, 0);
    chk("t6_clear_ovf", ovf_b, 0);

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), $urandom_range(0, 15));
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
